// File: rtl/ps2_key_parser.sv
// rtl/ps2_key_parser.sv - PS/2 scan-code sequence decoder with first-word-fall-through key-event FIFO
module ps2_key_parser #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_tick,
    input  logic       key_rd,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_brk,
    output logic       key_valid,
    output logic       overflow,
    output logic       err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW:0]   F_FULL = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tmo_cnt;
    logic          q_req, q_ext, q_brk, err_nxt, timeout;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          full, empty, push, pop;

    wire is_e0   = (scan_code == 8'hE0);
    wire is_f0   = (scan_code == 8'hF0);
    wire is_bad  = (scan_code == 8'h00) || (scan_code == 8'hFF);

    assign timeout = (state != IDLE) && (tmo_cnt == T_LAST);

    // Byte decode; a tick on the expiry cycle is decoded normally and masks the timeout.
    always_comb begin
        state_nxt = state;
        q_req     = 1'b0;
        q_ext     = 1'b0;
        q_brk     = 1'b0;
        err_nxt   = 1'b0;
        if (scan_tick) begin
            case (state)
                IDLE: begin
                    if (is_e0)       state_nxt = EXT;
                    else if (is_f0)  state_nxt = BRK;
                    else if (is_bad) err_nxt   = 1'b1;
                    else             q_req     = 1'b1;
                end
                EXT: begin
                    if (is_f0)       state_nxt = EXT_BRK;
                    else if (is_e0)  state_nxt = EXT;
                    else if (is_bad) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        q_req     = 1'b1;
                        q_ext     = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                BRK, EXT_BRK: begin
                    state_nxt = IDLE;
                    if (is_e0 || is_f0 || is_bad) begin
                        err_nxt = 1'b1;
                    end else begin
                        q_req = 1'b1;
                        q_ext = (state == EXT_BRK);
                        q_brk = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else if (timeout) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= err_nxt;
            if (scan_tick || state == IDLE || timeout)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign empty = (count == '0);
    assign full  = (count == F_FULL);
    assign pop   = key_rd && !empty;
    // A simultaneous pop frees a slot, so a write into a full FIFO still lands.
    assign push  = q_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {q_ext, q_brk, scan_code};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + (PW + 1)'(1);
            else if (pop && !push) count <= count - (PW + 1)'(1);
            if (q_req && !push)
                overflow <= 1'b1;
        end
    end

    assign key_valid = !empty;
    assign key_code  = key_valid ? mem[rd_ptr][7:0] : 8'h00;
    assign key_brk   = key_valid ? mem[rd_ptr][8]   : 1'b0;
    assign key_ext   = key_valid ? mem[rd_ptr][9]   : 1'b0;

endmodule

// File: tb/tb_ps2_key_parser.sv
// tb/tb_ps2_key_parser.sv - directed self-checking bench for ps2_key_parser
module tb_ps2_key_parser;

    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       scan_tick = 1'b0;
    logic       key_rd = 1'b0;
    logic [7:0] key_code;
    logic       key_ext, key_brk, key_valid, overflow, err;

    int total = 0;
    int bad = 0;
    int err_cnt = 0;
    int e0;

    ps2_key_parser #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .scan_code(scan_code), .scan_tick(scan_tick),
        .key_rd(key_rd), .key_code(key_code), .key_ext(key_ext), .key_brk(key_brk),
        .key_valid(key_valid), .overflow(overflow), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (err) err_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // head packed as {valid, ext, brk, code}
    task automatic chk_head(input string tag, input logic v, input logic x, input logic b,
                            input logic [7:0] c);
        chk(tag, 32'({key_valid, key_ext, key_brk, key_code}), 32'({v, x, b, c}));
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        scan_code = b;
        scan_tick = 1'b1;
        @(negedge clk);
        scan_tick = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk);
        key_rd = 1'b1;
        @(negedge clk);
        key_rd = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_head("reset_head", 1'b0, 1'b0, 1'b0, 8'h00);
        chk("reset_ovf", 32'(overflow), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        reset = 1'b1;

        send(8'h1C);
        chk_head("make_1c", 1'b1, 1'b0, 1'b0, 8'h1C);
        pop_one();
        chk("make_1c_pop", 32'(key_valid), 32'd0);

        send(8'hF0); send(8'h1C);
        chk_head("brk_1c", 1'b1, 1'b0, 1'b1, 8'h1C);
        pop_one();
        send(8'hE0); send(8'hF0); send(8'h75);
        chk_head("extbrk_75", 1'b1, 1'b1, 1'b1, 8'h75);
        pop_one();
        send(8'hE0); send(8'hE0); send(8'h6B);
        chk_head("ext_e0e0_6b", 1'b1, 1'b1, 1'b0, 8'h6B);
        pop_one();
        settle();
        chk("seq_no_err", 32'(err_cnt), 32'd0);
        chk("seq_empty", 32'(key_valid), 32'd0);

        for (int i = 0; i < 5; i++) send(8'h15 + 8'(i));
        chk("ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk_head($sformatf("ovf_head%0d", i), 1'b1, 1'b0, 1'b0, 8'h15 + 8'(i));
            pop_one();
        end
        chk("ovf_drained", 32'(key_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        for (int i = 0; i < 4; i++) send(8'h15 + 8'(i));
        @(negedge clk);
        scan_code = 8'h20;
        scan_tick = 1'b1;
        key_rd = 1'b1;
        @(negedge clk);
        scan_tick = 1'b0;
        key_rd = 1'b0;
        chk("full_rw_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk_head($sformatf("full_rw_head%0d", i), 1'b1, 1'b0, 1'b0,
                     (i == 3) ? 8'h20 : 8'h16 + 8'(i));
            pop_one();
        end
        chk("full_rw_empty", 32'(key_valid), 32'd0);

        e0 = err_cnt;
        send(8'hE0);
        repeat (TMO + 5) @(negedge clk);
        settle();
        chk("tmo_err_once", 32'(err_cnt - e0), 32'd1);
        chk("tmo_nothing", 32'(key_valid), 32'd0);
        send(8'h1C);
        chk_head("tmo_then_1c", 1'b1, 1'b0, 1'b0, 8'h1C);
        pop_one();

        // tick lands on the exact expiry edge
        e0 = err_cnt;
        send(8'hE0);
        repeat (TMO - 2) @(negedge clk);
        send(8'h6B);
        chk_head("tmo_prio_6b", 1'b1, 1'b1, 1'b0, 8'h6B);
        pop_one();
        repeat (TMO + 2) @(negedge clk);
        settle();
        chk("tmo_prio_no_err", 32'(err_cnt - e0), 32'd0);

        e0 = err_cnt;
        send(8'hF0); send(8'hE0);
        chk("f0e0_err", 32'(err), 32'd1);
        settle();
        chk("f0e0_err_pulse", 32'(err), 32'd0);
        chk("f0e0_nothing", 32'(key_valid), 32'd0);
        send(8'h00);
        chk("idle00_err", 32'(err), 32'd1);
        send(8'hFF);
        chk("idleff_err", 32'(err), 32'd1);
        settle();
        chk("err_count", 32'(err_cnt - e0), 32'd3);
        chk("bad_nothing", 32'(key_valid), 32'd0);

        send(8'h01); send(8'h02); send(8'h03); send(8'hE0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_head("rst_head", 1'b0, 1'b0, 1'b0, 8'h00);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b1;
        send(8'h1C);
        chk_head("rst_then_1c", 1'b1, 1'b0, 1'b0, 8'h1C);
        pop_one();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_parser.md
PS2_KEY_PARSER -- requirements
Module: ps2_key_parser

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: number of key-event entries buffered; power of two, minimum 2.
REQ-002 Parameter TIMEOUT_CYCLES, default 2500000: idle clk cycles after a prefix byte before the sequence is abandoned (50 ms at 50 MHz).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-005 scan_code  input  8  byte delivered by the PS/2 receiver; valid only while scan_tick=1.
REQ-006 scan_tick  input  1  one-cycle strobe marking a new scan_code byte.
REQ-007 key_rd  input  1  consumer pop request for the head event.
REQ-008 key_code  output  8  head event scan code without prefixes.
REQ-009 key_ext  output  1  head event was E0-prefixed.
REQ-010 key_brk  output  1  head event was a release (F0-prefixed).
REQ-011 key_valid  output  1  FIFO non-empty; key_code/key_ext/key_brk valid.
REQ-012 overflow  output  1  sticky flag: at least one event was dropped because the FIFO was full.
REQ-013 err  output  1  one-cycle pulse on a protocol error or timeout.

Function
REQ-014 The FSM SHALL have states IDLE, EXT, BRK and EXT_BRK and SHALL change state only on a cycle with scan_tick=1 or on timeout.
REQ-015 IDLE: E0 -> EXT; F0 -> BRK; 00 or FF -> err pulse, stay IDLE, nothing queued; any other byte -> queue {byte, ext=0, brk=0}, stay IDLE.
REQ-016 EXT: F0 -> EXT_BRK; E0 -> stay EXT, no error; 00/FF -> err, IDLE; other -> queue {byte,1,0}, IDLE.
REQ-017 BRK: E0 or F0 or 00/FF -> err pulse, IDLE, nothing queued; other -> queue {byte,0,1}, IDLE.
REQ-018 EXT_BRK: E0 or F0 or 00/FF -> err pulse, IDLE, nothing queued; other -> queue {byte,1,1}, IDLE.
REQ-019 The timeout counter SHALL clear on every scan_tick and in IDLE, SHALL increment each cycle in EXT, BRK and EXT_BRK, and on reaching TIMEOUT_CYCLES-1 SHALL force IDLE with an err pulse and no event queued.
REQ-020 scan_tick in the same cycle as timeout expiry SHALL take priority; the byte is processed and no timeout error is raised.
REQ-021 A queued event SHALL be written on the clock edge sampling scan_tick; with the FIFO empty, key_valid and the event fields SHALL appear in the cycle immediately after that edge (1-cycle latency).
REQ-022 The FIFO SHALL be first-word-fall-through; the head event is presented combinationally from storage while key_valid=1.
REQ-023 key_rd with key_valid=1 SHALL pop the head on that edge; key_rd with key_valid=0 SHALL be ignored.
REQ-024 A write when full with no simultaneous pop SHALL be discarded, FIFO contents unchanged, overflow set to 1 until reset.
REQ-025 A write and a pop on the same edge SHALL both succeed at any occupancy, including full; occupancy unchanged.
REQ-026 Read/write pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished with an extra occupancy bit or count, never by pointer equality alone.
REQ-027 err SHALL be high for exactly one cycle per error event and low otherwise.

Reset
REQ-028 While reset=0: state IDLE, FIFO empty, pointers and timeout counter 0, key_valid=0, key_code=8'h00, key_ext=0, key_brk=0, overflow=0, err=0.
REQ-029 Reset asserted mid-sequence or with a non-empty FIFO SHALL discard the partial sequence and all queued events; the first byte after release is decoded from IDLE.

Verification
REQ-030 scan_tick with 1C from IDLE -> next cycle key_valid=1, key_code=1C, key_ext=0, key_brk=0; key_rd -> key_valid=0.
REQ-031 F0,1C -> one event {1C,0,1}; E0,F0,75 -> one event {75,1,1}; E0,E0,6B -> one event {6B,1,0}; no err.
REQ-032 Five events 15,16,17,18,19 with no pops -> 15..18 retained in order, overflow=1; four pops drain 15,16,17,18, then key_valid=0; overflow stays 1.
REQ-033 FIFO full plus a new event and key_rd on the same edge -> 15 popped, new event becomes tail, overflow unchanged.
REQ-034 E0 then no byte for TIMEOUT_CYCLES cycles -> single err pulse, state IDLE, nothing queued; following 1C -> {1C,0,0}.
REQ-035 F0,E0 -> err pulse, nothing queued; 00 in IDLE -> err pulse; reset pulse with 3 events queued -> key_valid=0, overflow=0.
